// File: rtl/key_expand_ctrl_pkg.sv
// rtl/key_expand_ctrl_pkg.sv - shared state enum, widths and round count for AES-128 key expansion
package key_expand_ctrl_pkg;

  localparam int KEY_W      = 128;
  localparam int WORD_W     = 32;
  localparam int IDX_W      = 4;
  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_SUB,
    ST_MIX
  } state_t;

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expand_ctrl_rcon.sv
// rtl/key_expand_ctrl_rcon.sv - GF(16)-basis round constant lookup indexed by round counter
module key_expand_ctrl_rcon
  import key_expand_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0] round_idx,
  output logic [7:0]       rcon
);

  always_comb begin
    rcon = 8'h00;
    case (round_idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h2b;
      4'd2:    rcon = 8'h43;
      4'd3:    rcon = 8'h49;
      4'd4:    rcon = 8'h3b;
      4'd5:    rcon = 8'hd6;
      4'd6:    rcon = 8'h33;
      4'd7:    rcon = 8'he1;
      4'd8:    rcon = 8'h58;
      4'd9:    rcon = 8'h85;
      default: rcon = 8'h00;
    endcase
  end

endmodule

// File: rtl/key_expand_ctrl.sv
// rtl/key_expand_ctrl.sv - AES-128 key expansion sequencer over a shared external S-box
// Optional macro KEY_EXPAND_ZEROIZE_EN clears the working key when returning to IDLE.
module key_expand_ctrl
  import key_expand_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              busy,
  output logic              done,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [IDX_W-1:0]  rk_idx,
  output logic [KEY_W-1:0]  rk_data,
  output logic [WORD_W-1:0] sbox_in,
  input  logic [WORD_W-1:0] sbox_out
);

  state_t             state;
  logic [KEY_W-1:0]   key_q;
  logic [IDX_W-1:0]   round_q;
  logic [7:0]         rcon;
  logic [WORD_W-1:0]  temp, w0_n, w1_n, w2_n, w3_n;

  key_expand_ctrl_rcon u_rcon (
    .round_idx (round_q),
    .rcon      (rcon)
  );

  assign rk_data = key_q;
  assign rk_idx  = round_q;

  // Chained XOR: each new word folds in the freshly computed previous word.
  always_comb begin
    temp = sbox_out ^ {rcon, 24'h0};
    w0_n = key_q[127:96] ^ temp;
    w1_n = key_q[95:64]  ^ w0_n;
    w2_n = key_q[63:32]  ^ w1_n;
    w3_n = key_q[31:0]   ^ w2_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      key_q    <= '0;
      round_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_valid <= 1'b0;
      sbox_in  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_q    <= key_in;
            round_q  <= '0;
            state    <= ST_EMIT;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
            if (round_q == IDX_W'(NUM_ROUNDS)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
`ifdef KEY_EXPAND_ZEROIZE_EN
              key_q <= '0;
`else
              key_q <= key_q;
`endif
            end else begin
              state   <= ST_SUB;
              sbox_in <= rot_word(key_q[31:0]);
            end
          end
        end
        ST_SUB: begin
          // S-box result for the word driven here arrives in MIX.
          state   <= ST_MIX;
          sbox_in <= '0;
        end
        ST_MIX: begin
          key_q    <= {w0_n, w1_n, w2_n, w3_n};
          round_q  <= round_q + 1'b1;
          state    <= ST_EMIT;
          rk_valid <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb/tb_key_expand_ctrl.sv - self-checking bench for key_expand_ctrl with identity S-box stub
module tb_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [127:0] key_in;
  logic         busy, done, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [31:0]  sbox_in, sbox_out;

  int checks = 0;
  int errors = 0;

  logic [127:0] model_rk [0:10];
  logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h2b, 8'h43, 8'h49, 8'h3b,
                                   8'hd6, 8'h33, 8'he1, 8'h58, 8'h85};

  always #5 clk = ~clk;

  // Identity S-box with one cycle of latency.
  always_ff @(posedge clk) sbox_out <= sbox_in;

  key_expand_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_idx   (rk_idx),
    .rk_data  (rk_data),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Textbook word-list key schedule: w[i] = w[i-4] ^ f(w[i-1]).
  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = {t[23:0], t[31:24]} ^ {rcon_tab[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run_expand(input logic [127:0] key, input int stall_idx, input int stall_len,
                            input int start_cyc, input bit rand_ready);
    int cyc, n_xfer, stalled, last_xfer_cyc, last_idx, n_done, done_seen, done_exp, limit;
    bit holding, ready;
    logic [127:0] held_data;
    logic [3:0]   held_idx;
    logic [31:0]  w3;
    build_model(key);
    done_exp = 32 + stall_len;
    limit = rand_ready ? 300 : done_exp + 3;
    @(negedge clk);
    key_in = key; start = 1'b1; rk_ready = 1'b1;
    cyc = 0; n_xfer = 0; stalled = 0; last_xfer_cyc = -10; last_idx = -1;
    n_done = 0; done_seen = -1; holding = 1'b0; held_data = '0; held_idx = '0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (last_idx >= 0 && last_idx < 10 && cyc == last_xfer_cyc + 1) begin
        w3 = model_rk[last_idx][31:0];
        chk("sbox_in_rot", sbox_in, {w3[23:0], w3[31:24]});
      end else begin
        chk("sbox_in_zero", sbox_in, 0);
      end
      if (done) begin
        n_done++;
        if (done_seen < 0) done_seen = cyc;
      end
      if (!rand_ready) chk("busy", busy, cyc < done_exp);
      if (rk_valid) begin
        if (holding) begin
          chk("hold_data", rk_data, held_data);
          chk("hold_idx", rk_idx, held_idx);
        end
        chk("rk_idx", rk_idx, n_xfer);
        chk("rk_data", rk_data, (n_xfer <= 10) ? model_rk[n_xfer] : '0);
        if (rand_ready) ready = ($urandom_range(0, 2) != 0);
        else            ready = !(n_xfer == stall_idx && stalled < stall_len);
        if (!ready) begin
          stalled++;
          holding = 1'b1; held_data = rk_data; held_idx = rk_idx;
        end else begin
          if (!rand_ready)
            chk("xfer_cycle", cyc, 1 + 3*n_xfer + ((n_xfer >= stall_idx) ? stall_len : 0));
          last_idx = n_xfer;
          n_xfer++;
          last_xfer_cyc = cyc;
          holding = 1'b0;
        end
        rk_ready = ready;
      end else begin
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start = (cyc == start_cyc);
      if (start) key_in = {$urandom, $urandom, $urandom, $urandom};
      if (n_done > 0 && cyc >= done_seen + 2) break;
    end
    chk("xfer_count", n_xfer, 11);
    chk("done_count", n_done, 1);
    if (!rand_ready) chk("done_cycle", done_seen, done_exp);
    chk("busy_after", busy, 0);
    chk("valid_after", rk_valid, 0);
`ifdef KEY_EXPAND_ZEROIZE_EN
    chk("post_key_zero", rk_data, 0);
`else
    chk("post_key_kept", rk_data, model_rk[10]);
`endif
    start = 1'b0; rk_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", rk_valid, 0);
    chk("rst_idx", rk_idx, 0);
    chk("rst_data", rk_data, 0);
    chk("rst_sbox", sbox_in, 0);

    run_expand('0, 99, 0, -1, 1'b0);
    run_expand({$urandom, $urandom, $urandom, $urandom}, 99, 0, -1, 1'b0);
    run_expand({$urandom, $urandom, $urandom, $urandom}, 4, 5, -1, 1'b0);
    run_expand({$urandom, $urandom, $urandom, $urandom}, 99, 0, 10, 1'b0);
    run_expand({$urandom, $urandom, $urandom, $urandom}, 99, 0, 31, 1'b0);
    run_expand({$urandom, $urandom, $urandom, $urandom}, 99, 0, -1, 1'b1);
    run_expand({$urandom, $urandom, $urandom, $urandom}, 99, 0, -1, 1'b1);

    // Mid-run reset at cycle 15, with a competing start that reset must override.
    @(negedge clk);
    key_in = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1; rk_ready = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_valid", rk_valid, 0);
    chk("midrst_idx", rk_idx, 0);
    chk("midrst_data", rk_data, 0);
    chk("midrst_sbox", sbox_in, 0);
    rst = 1'b0; start = 1'b0;

    @(negedge clk);
    key_in = '0; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        chk("k0_valid", rk_valid, 1);
        chk("k0_idx", rk_idx, 0);
        chk("k0_data", rk_data, 128'h0);
      end
      if (c == 4) begin
        chk("k1_idx", rk_idx, 1);
        chk("k1_data", rk_data, 128'h01000000_01000000_01000000_01000000);
      end
      if (c == 7) begin
        chk("k2_idx", rk_idx, 2);
        chk("k2_data", rk_data, 128'h2a000001_2b000001_2a000001_2b000001);
      end
    end
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    chk("drain_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
